// File: rtl/mem_arb_pkg.sv
// +--------------------------------------------------------------------+
// | mem_arb_pkg: shared constants for the round-robin memory arbiter   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  localparam int ARB_N          = 3;
  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_RDATA = 2'd3;

endpackage

`default_nettype wire

// File: rtl/mem_cmd_fifo.sv
// +--------------------------------------------------------------------+
// | mem_cmd_fifo: synchronous command FIFO with occupancy count        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_cmd_fifo
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_req_agent.sv
// +--------------------------------------------------------------------+
// | mem_req_agent: requestor-side agent, one RAM access per grant      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_req_agent
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              req,
  input  logic              grant,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              starve,
  output logic              spurious_grant
);

  localparam int CMD_W  = 1 + ADDR_W + DATA_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] STARVE_THR = WAIT_W'(STARVE_LIMIT);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              req_q, req_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              spurious_q, spurious_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic [CMD_W-1:0]  fifo_rd_data;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign {head_we, head_addr, head_wdata} = fifo_rd_data;

  mem_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data ({cmd_we, cmd_addr, cmd_wdata}),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      req_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      req_q       <= req_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      spurious_q  <= spurious_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fifo_count != '0) state_d = ST_REQ;
      ST_REQ:   if (grant && !fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: state_d = mem_we_q ? ST_IDLE : ST_RDATA;
      ST_RDATA: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop    = (state_q == ST_REQ) && grant && !fifo_empty;
    req_d       = (state_d == ST_REQ);
    mem_en_d    = fifo_pop;
    mem_we_d    = fifo_pop && head_we;
    mem_addr_d  = fifo_pop ? head_addr : mem_addr_q;
    mem_wdata_d = fifo_pop ? head_wdata : mem_wdata_q;
    // RAM data is valid the cycle after the read strobe, i.e. while in RDATA.
    rsp_valid_d = (state_q == ST_RDATA);
    rsp_rdata_d = rsp_valid_d ? mem_rdata : rsp_rdata_q;
    spurious_d  = spurious_q || (grant && (state_q != ST_REQ));
    // Held at zero outside REQ so every entry into REQ starts from zero.
    wait_d      = '0;
    if (state_q == ST_REQ) begin
      wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
    end
  end

  assign req            = req_q;
  assign mem_en         = mem_en_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign spurious_grant = spurious_q;
  assign starve         = (state_q == ST_REQ) && (wait_q >= STARVE_THR);

endmodule

`default_nettype wire

// File: tb/tb_mem_req_agent.sv
// +--------------------------------------------------------------------+
// | tb_mem_req_agent: scoreboard bench with arbiter and RAM models     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mem_req_agent;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       req;
  logic       grant;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       starve;
  logic       spurious_grant;

  logic       auto_en;
  logic       auto_g;
  logic       man_g;
  logic       ram_init;
  logic [7:0] ram [256];
  logic [7:0] ref_mem [256];

  acc_t       exp_acc[$];
  logic [7:0] exp_rsp[$];
  acc_t       mon_e;
  logic [7:0] mon_d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign grant = auto_g | man_g;

  mem_req_agent #(
    .ADDR_W       (8),
    .DATA_W       (8),
    .DEPTH        (4),
    .STARVE_LIMIT (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_we         (cmd_we),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .req            (req),
    .grant          (grant),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .starve         (starve),
    .spurious_grant (spurious_grant)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h34) ? 8'h5C : (a ^ 8'hA7);
  endfunction

  // Arbiter stub: one-cycle grant in the cycle after req is sampled.
  always @(posedge clk) begin
    if (reset) auto_g <= 1'b0;
    else       auto_g <= auto_en && req && !auto_g;
  end

  // Synchronous RAM: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(8'(i));
      mem_rdata <= 8'h00;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (mem_en) begin
      n_tests++;
      if (exp_acc.size() == 0) begin
        n_fail++;
        $display("FAIL access_unexpected: mem_en=1 addr=%h we=%b, required no access", mem_addr, mem_we);
      end else begin
        mon_e = exp_acc.pop_front();
        if (mem_we !== mon_e.we || mem_addr !== mon_e.addr || (mon_e.we && mem_wdata !== mon_e.wdata)) begin
          n_fail++;
          $display("FAIL access_order: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                   mem_we, mem_addr, mem_wdata, mon_e.we, mon_e.addr, mon_e.wdata);
        end
      end
    end
    if (rsp_valid) begin
      n_tests++;
      if (exp_rsp.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: rsp_valid=1 rdata=%h, required no response", rsp_rdata);
      end else begin
        mon_d = exp_rsp.pop_front();
        if (rsp_rdata !== mon_d) begin
          n_fail++;
          $display("FAIL rsp_data: got %h, required %h", rsp_rdata, mon_d);
        end
      end
    end
  end

  task automatic send(input logic we, input logic [7:0] addr, input logic [7:0] data, input bit hold);
    acc_t a;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = data;
    for (int k = 0; k < 100 && cmd_ready !== 1'b1; k++) @(negedge clk);
    if (cmd_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: cmd_ready=%b, required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    a.we = we; a.addr = addr; a.wdata = data;
    exp_acc.push_back(a);
    if (we) ref_mem[addr] = data;
    else    exp_rsp.push_back(ref_mem[addr]);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (exp_acc.size() == 0 && exp_rsp.size() == 0 && req === 1'b0) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d accesses and %0d responses outstanding, required 0",
               exp_acc.size(), exp_rsp.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ram_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({req, mem_en, mem_we, rsp_valid, starve, spurious_grant} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: req/en/we/rsp/starve/spur=%b, required 000000",
               {req, mem_en, mem_we, rsp_valid, starve, spurious_grant});
    end
    n_tests++;
    if ({mem_addr, mem_wdata, rsp_rdata} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr/wdata/rdata=%h, required 000000", {mem_addr, mem_wdata, rsp_rdata});
    end
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
    end
    reset = 1'b0; ram_init = 1'b0;
  endtask

  task automatic test_single_write();
    send(1'b1, 8'h12, 8'hA5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) begin
        n_tests++;
        if (req !== 1'b1) begin n_fail++; $display("FAIL wr_req_rise: req=%b, required 1", req); end
      end
      if (i == 2) begin
        n_tests++;
        if (mem_en !== 1'b0) begin n_fail++; $display("FAIL wr_early_en: mem_en=%b, required 0", mem_en); end
      end
      if (i == 3) begin
        n_tests++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, req} !== {1'b1, 1'b1, 8'h12, 8'hA5, 1'b0}) begin
          n_fail++;
          $display("FAIL wr_issue: en=%b we=%b addr=%h wdata=%h req=%b, required 1 1 12 a5 0",
                   mem_en, mem_we, mem_addr, mem_wdata, req);
        end
      end
      if (i == 4) begin
        n_tests++;
        if ({mem_en, mem_we} !== 2'b00) begin n_fail++; $display("FAIL wr_en_drop: en/we=%b, required 00", {mem_en, mem_we}); end
      end
    end
    wait_idle();
  endtask

  task automatic test_read();
    send(1'b0, 8'h34, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 4) begin
        n_tests++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early_rsp: rsp_valid=%b, required 0", rsp_valid); end
      end
      if (i == 5) begin
        n_tests++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h5C}) begin
          n_fail++;
          $display("FAIL rd_rsp: valid=%b rdata=%h, required 1 5c", rsp_valid, rsp_rdata);
        end
      end
      if (i == 8) begin
        n_tests++;
        if ({rsp_valid, rsp_rdata} !== {1'b0, 8'h5C}) begin
          n_fail++;
          $display("FAIL rd_hold: valid=%b rdata=%h, required 0 5c", rsp_valid, rsp_rdata);
        end
      end
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    auto_en = 1'b0;
    send(1'b1, 8'h10, 8'h11, 1'b1);
    send(1'b0, 8'h10, 8'h00, 1'b1);
    send(1'b1, 8'h20, 8'h22, 1'b1);
    send(1'b0, 8'h21, 8'h00, 1'b1);
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: cmd_ready=%b, required 0", cmd_ready); end
    auto_en = 1'b1;
    send(1'b1, 8'h30, 8'h33, 1'b0);
    wait_idle();
  endtask

  task automatic test_starve();
    bit seen = 1'b0;
    auto_en = 1'b0;
    send(1'b1, 8'h50, 8'h55, 1'b0);
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (req === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL starve_req: req=%b, required 1", req); end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_tests++;
      if (starve !== (i >= 16)) begin
        n_fail++;
        $display("FAIL starve_level: cycle %0d starve=%b, required %b", i, starve, (i >= 16));
      end
    end
    man_g = 1'b1;
    @(negedge clk);
    man_g = 1'b0;
    n_tests++;
    if ({starve, req, mem_en} !== 3'b001) begin
      n_fail++;
      $display("FAIL starve_clear: starve/req/en=%b, required 001", {starve, req, mem_en});
    end
    wait_idle();
    auto_en = 1'b1;
  endtask

  task automatic test_spurious();
    @(negedge clk);
    man_g = 1'b1;
    @(negedge clk);
    man_g = 1'b0;
    n_tests++;
    if ({spurious_grant, mem_en} !== 2'b10) begin
      n_fail++;
      $display("FAIL spur_set: spurious/en=%b, required 10", {spurious_grant, mem_en});
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if ({spurious_grant, req} !== 2'b10) begin
      n_fail++;
      $display("FAIL spur_sticky: spurious/req=%b, required 10", {spurious_grant, req});
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    auto_en = 1'b1;
    send(1'b0, 8'h60, 8'h00, 1'b1);
    send(1'b1, 8'h61, 8'h01, 1'b1);
    send(1'b1, 8'h62, 8'h02, 1'b0);
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (mem_en === 1'b1 && mem_we === 1'b0) found = 1'b1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL rst_issue: no read strobe seen, required one"); end
    @(negedge clk);
    n_tests++;
    if (dut.fifo_count !== 3'd2) begin n_fail++; $display("FAIL rst_pre_count: count=%0d, required 2", dut.fifo_count); end
    reset = 1'b1;
    exp_acc.delete();
    exp_rsp.delete();
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if ({rsp_valid, req, spurious_grant, cmd_ready} !== 4'b0001 || dut.fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid: rsp/req/spur/ready=%b count=%0d, required 0001 count 0",
               {rsp_valid, req, spurious_grant, cmd_ready}, dut.fifo_count);
    end
    send(1'b0, 8'h34, 8'h00, 1'b0);
    wait_idle();
    n_tests++;
    if (rsp_rdata !== 8'h5C) begin n_fail++; $display("FAIL rst_after: rsp_rdata=%h, required 5c", rsp_rdata); end
  endtask

  initial begin
    reset = 1'b1; ram_init = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    auto_en = 1'b1; man_g = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    test_reset();
    test_single_write();
    test_read();
    test_back_to_back();
    test_starve();
    test_spurious();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mem_req_agent.md
# mem_req_agent

Requestor-side agent for the 3-way round-robin memory arbiter. One instance per requestor slot. It buffers read/write commands from a client, raises `req`, waits for the arbiter's one-cycle `grant`, then drives a single synchronous-RAM access per grant and returns read data to the client. It is the initiator end of the `req`/`grant` interface whose responder is the arbiter.

## Interface
- `ADDR_W`, 8, memory address width
- `DATA_W`, 8, memory data width
- `DEPTH`, 4, command FIFO entries (power of two, ≥2)
- `STARVE_LIMIT`, 16, consecutive cycles in REQ before `starve` asserts
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `cmd_valid`  in  1  client command present
- `cmd_ready`  out  1  FIFO can accept; `= (count != DEPTH)`
- `cmd_we`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  command address
- `cmd_wdata`  in  DATA_W  write data (ignored for reads)
- `req`  out  1  to arbiter `req[i]`
- `grant`  in  1  from arbiter `grant[i]`
- `mem_en`, `mem_we`  out  1  RAM strobe / write enable
- `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W
- `mem_rdata`  in  DATA_W  valid the cycle after a read strobe
- `rsp_valid`  out  1  one-cycle read-response pulse
- `rsp_rdata`  out  DATA_W  read data, held until next response
- `starve`  out  1  level, wait counter ≥ STARVE_LIMIT
- `spurious_grant`  out  1  sticky; grant seen outside REQ

## Operation
- Push on `cmd_valid & cmd_ready`. Pop only in the REQ→ISSUE transition. Push and pop on the same edge leave `count` unchanged. No push bypass when full.
- FSM states are IDLE, REQ, ISSUE and RDATA.
  - IDLE: `req=0`. If `count>0` → REQ.
  - REQ: `req=1`. The wait counter increments, saturating at all-ones. If `grant=1` → ISSUE: pop the head and register it into the `mem_*` outputs.
  - ISSUE: `mem_en=1` for exactly one cycle, `req=0`. Write → IDLE. Read → RDATA.
  - RDATA: at the edge leaving RDATA, capture `mem_rdata` into `rsp_rdata`, pulse `rsp_valid`, then → IDLE.
- `req` is registered and equals `(state==REQ)`. `req` drops for at least one cycle between accesses, which matches the arbiter's one-cycle grant slots.
- The wait counter clears on entry to REQ. `starve` is combinational from the counter and the state.
- A grant seen in IDLE, ISSUE or RDATA is ignored, performs no access, and sets `spurious_grant` until reset.
- `mem_addr`/`mem_wdata` hold their last values when `mem_en=0`. `mem_we` is 0 whenever `mem_en=0`.
- Reset, including mid-operation: FSM → IDLE, FIFO flushed, any in-flight read dropped with no `rsp_valid`, wait counter cleared.

## Timing
- Reset values: `req`, `mem_en`, `mem_we`, `rsp_valid`, `starve` and `spurious_grant` are 0. `mem_addr`, `mem_wdata` and `rsp_rdata` are 0. `cmd_ready` is 1.
- Best case, with the command accepted at edge E0:
  - `req` high after E1.
  - Arbiter samples `req` at E2; `grant` high after E2.
  - Agent samples `grant` at E3; `mem_en` high during E3–E4.
  - For a read, `rsp_valid` high during E5–E6.
- Each extra cycle `grant` is withheld adds one cycle to every later edge.
- Throughput is at most one access per 3 cycles (writes) or 4 cycles (reads).

## Structure
- Shared package `mem_arb_pkg` holds:
  - the FSM state encodings (IDLE=2'd0, REQ=2'd1, ISSUE=2'd2, RDATA=2'd3);
  - `ARB_N=3`;
  - default `ADDR_W`/`DATA_W`.
- Sub-module `mem_cmd_fifo`: synchronous FIFO, width `1+ADDR_W+DATA_W`, depth `DEPTH`, exposing `count`, `full` and `empty`. The FSM, counters and output registers stay in `mem_req_agent`.

## Test plan
- Single write {we=1, addr=0x12, data=0xA5}, arbiter stub grants one cycle after `req`: `mem_en`/`mem_we` high once, at E3, with addr 0x12 and wdata 0xA5. `req` low after E3. No `rsp_valid`.
- Read addr 0x34, RAM returns 0x5C: `rsp_valid` one cycle after E5 with `rsp_rdata=0x5C`. `rsp_rdata` holds afterwards.
- Push 5 commands back-to-back with DEPTH=4: `cmd_ready` low after the 4th accept. The 5th is accepted only after the first pop. All 5 accesses occur in order.
- Grant withheld 20 cycles: `starve` rises after 16 REQ cycles. It clears when the grant arrives and the FSM leaves REQ.
- Grant pulsed while IDLE: no `mem_en`. `spurious_grant` goes to 1 and stays set until reset.
- Reset asserted in RDATA with 2 entries queued: no `rsp_valid`, `count=0`, `req=0` after the reset edge. A new command then completes normally.
